// File: rtl/reset_sequencer_if.sv
// Reset sequencer pin bundle: raw button and PLL lock in, PLL/CPU resets and
// debug status out. clk_50 and resb stay as plain ports on the sequencer.
interface reset_sequencer_if;
  logic       button_reset;    // raw push-button, 0 = pressed
  logic       pll_cpu_locked;  // asynchronous PLL lock flag
  logic       pll_cpu_reset;   // PLL reset, active low
  logic       cpu_resb;        // CPU reset, active low
  logic       lock_fail;       // sticky lock-timeout flag
  logic [2:0] seq_state;       // FSM state for debug

  // Sequencer side
  modport master (
    input  button_reset,
    input  pll_cpu_locked,
    output pll_cpu_reset,
    output cpu_resb,
    output lock_fail,
    output seq_state
  );

  // Board / environment side
  modport slave (
    output button_reset,
    output pll_cpu_locked,
    input  pll_cpu_reset,
    input  cpu_resb,
    input  lock_fail,
    input  seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Power-up and push-button reset sequencer for the 65C02 system.
// Resets the CPU PLL, qualifies its lock, holds the CPU in reset for a fixed
// time, then releases it. A debounced button press or loss of lock puts the
// CPU back into reset. All outputs come straight from registers.
module reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES     = 500000,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CPU_RESET_HOLD      = 200
) (
  input  logic                  clk_50,
  input  logic                  resb,
  reset_sequencer_if.master     seq_if
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One counter width wide enough for the largest limit, so no counter wraps.
  localparam int unsigned MAX_P = max2(max2(max2(DEBOUNCE_CYCLES, PLL_RESET_CYCLES),
                                            max2(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)),
                                       CPU_RESET_HOLD);
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_OK_CNT = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CPU_RESET_HOLD - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_BTN       = 3'd4
  } state_t;

  // Synchronisers
  logic             btn_meta_q;
  logic             btn_sync_q;
  logic             lock_meta_q;
  logic             lock_sync_q;

  // Debounce
  logic             btn_deb_q,  btn_deb_d;
  logic [CNT_W-1:0] deb_cnt_q,  deb_cnt_d;

  // Lock qualifier
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_ok_s;

  // Sequencer FSM and its registered outputs
  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             pll_rst_n_q, pll_rst_n_d;
  logic             cpu_resb_q,  cpu_resb_d;
  logic             lock_fail_q, lock_fail_d;

  // Two-flop synchronisers for the asynchronous button and lock inputs
  always_ff @(posedge clk_50) begin
    if (!resb) begin
      btn_meta_q  <= 1'b1;
      btn_sync_q  <= 1'b1;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= seq_if.button_reset;
      btn_sync_q  <= btn_meta_q;
      lock_meta_q <= seq_if.pll_cpu_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Debounce: count cycles the synchronised button disagrees with the accepted
  // level; a single agreeing cycle restarts the count, so short glitches die.
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = deb_cnt_q;
    if (btn_sync_q == btn_deb_q) begin
      deb_cnt_d = CNT_ZERO;
    end else if (deb_cnt_q == DEB_LAST) begin
      btn_deb_d = btn_sync_q;
      deb_cnt_d = CNT_ZERO;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_50) begin
    if (!resb) begin
      btn_deb_q <= 1'b1;
      deb_cnt_q <= CNT_ZERO;
    end else begin
      btn_deb_q <= btn_deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Lock qualifier: consecutive high cycles, saturating at the stable count
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_sync_q) begin
      lock_cnt_d = CNT_ZERO;
    end else if (lock_cnt_q == LOCK_OK_CNT) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + CNT_ONE;
    end
  end

  assign lock_ok_s = (lock_cnt_q == LOCK_OK_CNT);

  // Lock qualifier register
  always_ff @(posedge clk_50) begin
    if (!resb) begin
      lock_cnt_q <= CNT_ZERO;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next-state logic; lock loss outranks button press and count expiry.
  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    lock_fail_d = lock_fail_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLLRST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_ok_s) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = ST_PLL_RST;
          cnt_d       = CNT_ZERO;
          lock_fail_d = 1'b1;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (!lock_sync_q) begin
          state_d = ST_PLL_RST;
          cnt_d   = CNT_ZERO;
        end else if (!btn_deb_q) begin
          state_d = ST_BTN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        cnt_d = CNT_ZERO;
        if (!lock_sync_q) begin
          state_d = ST_PLL_RST;
        end else if (!btn_deb_q) begin
          state_d = ST_BTN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BTN: begin
        cnt_d = CNT_ZERO;
        if (!lock_sync_q) begin
          state_d = ST_PLL_RST;
        end else if (btn_deb_q) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_BTN;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = CNT_ZERO;
      end
    endcase

    pll_rst_n_d = (state_d != ST_PLL_RST);
    cpu_resb_d  = (state_d == ST_RUN);
  end

  // FSM state, in-state counter and registered outputs
  always_ff @(posedge clk_50) begin
    if (!resb) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= CNT_ZERO;
      pll_rst_n_q <= 1'b0;
      cpu_resb_q  <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_n_q <= pll_rst_n_d;
      cpu_resb_q  <= cpu_resb_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign seq_if.pll_cpu_reset = pll_rst_n_q;
  assign seq_if.cpu_resb      = cpu_resb_q;
  assign seq_if.lock_fail     = lock_fail_q;
  assign seq_if.seq_state     = state_q;

endmodule
